// File: rtl/audio_voice_engine.sv
// audio_voice_engine: time-multiplexed multi-voice tone/noise generator with
// per-voice decay envelope, saturating mixer and first-order sigma-delta output.
module audio_voice_engine #(
   parameter int NUM_VOICES   = 4,
   parameter int DIV_BITS     = 10,
   parameter int INC_W        = 12,
   parameter int ENV_DIV_BITS = 8,
   localparam int VW          = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                  clk48,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [VW-1:0]         wr_voice,
   input  logic [1:0]            wr_reg,
   input  logic [15:0]           wr_data,
   input  logic [NUM_VOICES-1:0] key_on,
   output logic [15:0]           audio_sample,
   output logic                  sample_valid,
   output logic                  out
);

   localparam int AW = 17 + $clog2(NUM_VOICES);
   localparam logic [DIV_BITS-1:0] SDIV_OUT = DIV_BITS'(NUM_VOICES);
   localparam logic signed [AW-1:0] SAT_HI = AW'(32767);
   localparam logic signed [AW-1:0] SAT_LO = AW'(-32768);

   logic [DIV_BITS-1:0]     sdiv_q;
   logic [ENV_DIV_BITS-1:0] scnt_q;
   logic signed [AW-1:0]    acc_q, acc_d;
   logic [15:0]             audio_q;
   logic                    valid_q;
   logic [15:0]             sd_q;
   logic                    out_q;

   logic [15:0]      phase_q [NUM_VOICES];
   logic [INC_W-1:0] inc_q   [NUM_VOICES];
   logic [1:0]       mode_q  [NUM_VOICES];
   logic [3:0]       dec_q   [NUM_VOICES];
   logic [3:0]       iatt_q  [NUM_VOICES];
   logic [3:0]       att_q   [NUM_VOICES];
   logic [3:0]       ecnt_q  [NUM_VOICES];
   logic [14:0]      lfsr_q  [NUM_VOICES];

   logic               hit;
   logic [15:0]        p_sel;
   logic [1:0]         m_sel;
   logic [14:0]        l_sel;
   logic [3:0]         a_sel;
   logic [15:0]        tri_raw;
   logic signed [15:0] wave;
   logic signed [15:0] shifted;
   logic signed [AW-1:0] contrib;
   logic [15:0]        sat;
   logic [16:0]        sd_sum;
   logic               env_tick;
   logic               unused_wr;

   assign unused_wr = ^wr_data;
   assign env_tick  = (sdiv_q == '1) && (scnt_q == '1);
   assign sd_sum    = {1'b0, sd_q} + {1'b0, audio_q};

   // Select the voice owning this slot, build its waveform and attenuated contribution.
   always_comb begin
      hit   = 1'b0;
      p_sel = '0;
      m_sel = '0;
      l_sel = '0;
      a_sel = 4'hF;
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
         if (sdiv_q == DIV_BITS'(v)) begin
            hit   = 1'b1;
            p_sel = phase_q[v];
            m_sel = mode_q[v];
            l_sel = lfsr_q[v];
            a_sel = att_q[v];
         end
      end
      tri_raw = (p_sel ^ {16{p_sel[15]}}) - 16'd16384;
      case (m_sel)
         2'd0:    wave = p_sel[15] ? -16'sd8192 : 16'sd8192;
         2'd1:    wave = $signed(tri_raw) >>> 1;
         2'd2:    wave = $signed(p_sel) >>> 2;
         default: wave = {{3{l_sel[12]}}, l_sel[12:0]};
      endcase
      shifted = wave >>> a_sel;
      contrib = (hit && (a_sel != 4'hF)) ? {{(AW-16){shifted[15]}}, shifted} : '0;
      acc_d   = (sdiv_q == SDIV_OUT) ? '0 : acc_q + contrib;
      if (acc_q > SAT_HI)      sat = 16'h7FFF;
      else if (acc_q < SAT_LO) sat = 16'h8000;
      else                     sat = acc_q[15:0];
   end

   // Slot/sample counters, mixer accumulator, sample output and sigma-delta modulator.
   always_ff @(posedge clk48) begin
      if (rst) begin
         sdiv_q  <= '0;
         scnt_q  <= '0;
         acc_q   <= '0;
         audio_q <= 16'h8000;
         valid_q <= 1'b0;
         sd_q    <= '0;
         out_q   <= 1'b0;
      end else begin
         sdiv_q <= sdiv_q + 1'b1;
         if (sdiv_q == '1) scnt_q <= scnt_q + 1'b1;
         acc_q <= acc_d;
         if (sdiv_q == SDIV_OUT) audio_q <= sat ^ 16'h8000;
         valid_q <= (sdiv_q == SDIV_OUT);
         sd_q    <= sd_sum[15:0];
         out_q   <= sd_sum[16];
      end
   end

   // Per-voice registers: phase/LFSR advance, register writes, key-on and envelope decay.
   always_ff @(posedge clk48) begin
      if (rst) begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            phase_q[v] <= '0;
            inc_q[v]   <= '0;
            mode_q[v]  <= '0;
            dec_q[v]   <= '0;
            ecnt_q[v]  <= '0;
            iatt_q[v]  <= 4'hF;
            att_q[v]   <= 4'hF;
            lfsr_q[v]  <= 15'h1CAF;
         end
      end else begin
         for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            if (sdiv_q == DIV_BITS'(v)) begin
               phase_q[v] <= phase_q[v] + 16'(inc_q[v]);
               lfsr_q[v]  <= {lfsr_q[v][0], lfsr_q[v][0] ^ lfsr_q[v][14], lfsr_q[v][13:1]};
            end
            if (wr_en && (wr_voice == VW'(v))) begin
               case (wr_reg)
                  2'd0: inc_q[v] <= wr_data[INC_W-1:0];
                  2'd1: begin
                     mode_q[v] <= wr_data[1:0];
                     dec_q[v]  <= wr_data[7:4];
                  end
                  2'd2: iatt_q[v] <= wr_data[3:0];
                  default: ;
               endcase
            end
            // key_on samples the pre-write init_atten and overrides a same-cycle tick
            if (key_on[v]) begin
               att_q[v]  <= iatt_q[v];
               ecnt_q[v] <= '0;
            end else if (env_tick && (dec_q[v] != 4'd0)) begin
               if (ecnt_q[v] >= dec_q[v] - 4'd1) begin
                  ecnt_q[v] <= '0;
                  att_q[v]  <= (att_q[v] == 4'hF) ? 4'hF : att_q[v] + 4'd1;
               end else begin
                  ecnt_q[v] <= ecnt_q[v] + 4'd1;
               end
            end
         end
      end
   end

   assign audio_sample = audio_q;
   assign sample_valid = valid_q;
   assign out          = out_q;

endmodule

// File: doc/audio_voice_engine.md
AUDIO_VOICE_ENGINE -- requirements
Module: audio_voice_engine

Interface
REQ-001 Parameter NUM_VOICES, default 4, SHALL set the number of voices (legal range 1..8).
REQ-002 Parameter DIV_BITS, default 10, SHALL set clocks per sample to 2^DIV_BITS, with 2^DIV_BITS >= NUM_VOICES+2.
REQ-003 Parameter INC_W, default 12, SHALL set the phase-increment width per voice (legal range 1..16).
REQ-004 Parameter ENV_DIV_BITS, default 8, SHALL set samples per envelope tick to 2^ENV_DIV_BITS.
REQ-005 Port clk48, input, 1: SHALL be the single clock; every flop is on its rising edge.
REQ-006 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-007 Port wr_en, input, 1: SHALL be the register write strobe, sampled each clock.
REQ-008 Port wr_voice, input, VW = max(1, clog2(NUM_VOICES)): SHALL be the target voice; writes with wr_voice >= NUM_VOICES are ignored.
REQ-009 Port wr_reg, input, 2: SHALL select the register: 0 = inc, 1 = mode/decay, 2 = init_atten, 3 = ignored.
REQ-010 Port wr_data, input, 16: SHALL carry the write data (reg0 uses [INC_W-1:0]; reg1 uses mode [1:0] and decay D [7:4]; reg2 uses [3:0]).
REQ-011 Port key_on, input, NUM_VOICES: SHALL act as a per-voice level trigger; it retriggers on every cycle it is high.
REQ-012 Port audio_sample, output, 16: SHALL be the mixed sample, offset-binary.
REQ-013 Port sample_valid, output, 1: SHALL pulse for one cycle when audio_sample updates.
REQ-014 Port out, output, 1: SHALL be the first-order sigma-delta bitstream.

Function
REQ-015 A DIV_BITS-bit counter sdiv SHALL free-run from 0 and wrap at 2^DIV_BITS.
REQ-016 Processing of voice v (time-multiplexed, one voice per cycle) SHALL occur when sdiv == v, as follows:
- compute wave w from the current phase p (16 bits);
- add (w >>> atten) to a signed accumulator of width 17+clog2(NUM_VOICES), adding 0 when atten == 15;
- update p <= p + zero-extended inc (wraps mod 2^16);
- step the voice LFSR: lfsr <= {l[0], l[0]^l[14], l[13:1]}.
REQ-017 Waveform by mode SHALL be:
- 0 square: p[15] ? -8192 : +8192;
- 1 triangle: ((p ^ {16{p[15]}}) - 16384) >>> 1;
- 2 saw: signed(p) >>> 2;
- 3 noise: sign-extended lfsr[12:0].
REQ-018 Output update SHALL occur when sdiv == NUM_VOICES:
- the accumulator saturates to [-32768, 32767];
- audio_sample <= sat ^ 16'h8000 and the accumulator clears;
- sample_valid is high during the cycle sdiv == NUM_VOICES+1 and low otherwise.
REQ-019 Sigma-delta SHALL operate every clock: s = sd_acc + audio_sample (17 bits); sd_acc <= s[15:0]; out <= s[16].
REQ-020 An envelope tick SHALL occur when sdiv wraps to 0 on every 2^ENV_DIV_BITS-th sample (sample counter wrap).
- For each voice with D != 0: if env_cnt >= D-1 then env_cnt <= 0 and atten <= min(atten+1, 15); else env_cnt++.
- D == 0 means no decay.
REQ-021 key_on[v] SHALL set atten <= init_atten (pre-write value if written the same cycle) and env_cnt <= 0; key_on wins over a same-cycle envelope tick.
REQ-022 A write SHALL take effect the next cycle; an inc write during that voice's processing cycle SHALL affect the next sample only.
REQ-023 Phase and LFSR SHALL run regardless of atten; key_on SHALL NOT reset phase.

Reset
REQ-024 On rst the following SHALL hold:
- sdiv, sample counter, accumulator, sd_acc, phases, inc, mode, D and env_cnt = 0;
- init_atten and atten = 15;
- lfsr = 15'h1CAF;
- audio_sample = 16'h8000; sample_valid = 0; out = 0.
REQ-025 Reset asserted mid-sample SHALL discard the partial accumulation; the first post-reset sample_valid SHALL occur at cycle NUM_VOICES+1 after release (sdiv = 0 on the first cycle).

Verification (NUM_VOICES=4, DIV_BITS=10, ENV_DIV_BITS=8)
REQ-026 Idle after reset -> audio_sample stays 0x8000; out alternates 0,1; sample_valid exactly every 1024 clocks.
REQ-027 Voice0 mode 0, init 0, inc 0x100, key_on -> audio_sample 0xA000 for 128 samples, then 0x6000 for 128 samples, repeating.
REQ-028 All 4 voices mode 0, atten 0, phase 0 -> sum 32768 saturates; audio_sample = 0xFFFF.
REQ-029 Voice0 square, init 0, D = 1 -> magnitude halves every 256 samples; audio_sample = 0x8000 from the 15th tick onward.
REQ-030 Same-cycle key_on[0] with a reg2 write of 3 while init is 0 -> atten = 0 (old value); the next key_on gives atten = 3.
REQ-031 rst pulsed at sdiv = 2 with voices active -> all state equals the REQ-024 values; the next sample_valid comes 5 cycles after release.
